// File: rtl/alu_op_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer_pkg
// Shared definitions for the ALU operation sequencer:
//   - sequencer state encoding
//   - ALU Function code constants
//   - program entry layout {Function, Data}
// -----------------------------------------------------------------------------
package alu_op_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // ALU Function codes
    localparam logic [2:0] FN_ADD_FA  = 3'b000;
    localparam logic [2:0] FN_ADD     = 3'b001;
    localparam logic [2:0] FN_SEXT    = 3'b010;
    localparam logic [2:0] FN_OR_RED  = 3'b011;
    localparam logic [2:0] FN_AND_RED = 3'b100;
    localparam logic [2:0] FN_SHL     = 3'b101;
    localparam logic [2:0] FN_MUL     = 3'b110;
    localparam logic [2:0] FN_HOLD    = 3'b111;

    localparam int ENTRY_W = 7;

    typedef struct packed {
        logic [2:0] func;
        logic [3:0] data;
    } prog_entry_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer_if
// Groups the sequencer's program-load / control inputs and ALU-side outputs.
//   master : drives Clear, Load, LoadFunction, LoadData, Start; observes the rest
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface alu_op_sequencer_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          Clear;
    logic          Load;
    logic [2:0]    LoadFunction;
    logic [3:0]    LoadData;
    logic          Start;
    logic [3:0]    Data;
    logic [2:0]    Function;
    logic          AluReset_b;
    logic          Busy;
    logic          Done;
    logic          Full;
    logic [CW-1:0] Count;

    modport master (
        output Clear, Load, LoadFunction, LoadData, Start,
        input  Data, Function, AluReset_b, Busy, Done, Full, Count
    );

    modport slave (
        input  Clear, Load, LoadFunction, LoadData, Start,
        output Data, Function, AluReset_b, Busy, Done, Full, Count
    );
endinterface

// File: rtl/alu_op_sequencer_op_program_ram.sv
// -----------------------------------------------------------------------------
// op_program_ram
// DEPTH x 7-bit program store. Synchronous write, combinational read.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : {Function, Data} entry to write
//   raddr_i : read address
//   rdata_o : entry at raddr_i
// Contents are not reset; only entries below the stored count are ever read.
// -----------------------------------------------------------------------------
module op_program_ram
    import alu_op_sequencer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  prog_entry_t   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output prog_entry_t   rdata_o
);

    prog_entry_t mem_q [DEPTH];

    // Program write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Stores a short program of ALU operations and replays it into a registered
// 4-bit ALU: one ALU-clear cycle, then one {Function, Data} per clock, then a
// one-cycle Done pulse.
//   Clock, Reset_b : clock (rising edge) and asynchronous active-low reset
//   bus (slave)    : Clear/Load/LoadFunction/LoadData/Start in;
//                    Data/Function/AluReset_b (registered), Busy, Done,
//                    Full, Count out
// -----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int         DEPTH         = 8,
    parameter logic [2:0] IDLE_FUNCTION = FN_HOLD
) (
    input  logic               Clock,
    input  logic               Reset_b,
    alu_op_sequencer_if.slave  bus
);

    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};

    seq_state_t    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] index_q, index_d;
    logic [3:0]    data_q, data_d;
    logic [2:0]    func_q, func_d;
    logic          alu_rst_b_q, alu_rst_b_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          we_s;
    logic          full_s;
    logic          last_s;
    prog_entry_t   rd_entry_s;

    assign full_s = (count_q == DEPTH_C);
    assign last_s = ({1'b0, index_q} == (count_q - CNT_ONE));

    // Program store; read address follows next index so outputs register in step
    op_program_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (Clock),
        .we_i    (we_s),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i ({bus.LoadFunction, bus.LoadData}),
        .raddr_i (index_d),
        .rdata_o (rd_entry_s)
    );

    // State, program count and run index next-state logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        we_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.Clear) begin
                    count_d = '0;
                end else if (bus.Start) begin
                    // Start always swallows a same-cycle Load, even if empty
                    if (count_q != '0) begin
                        state_d = ST_CLEAR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (bus.Load && !full_s) begin
                    we_s    = 1'b1;
                    count_d = count_q + CNT_ONE;
                end else begin
                    count_d = count_q;
                end
            end
            ST_CLEAR: begin
                index_d = '0;
                if (bus.Clear) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.Clear) begin
                    state_d = ST_IDLE;
                end else if (last_s) begin
                    state_d = ST_DONE;
                end else begin
                    index_d = index_q + IDX_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the cycle about to start, decoded from the next state
    always_comb begin
        data_d      = 4'd0;
        func_d      = IDLE_FUNCTION;
        alu_rst_b_d = 1'b1;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            ST_CLEAR: begin
                alu_rst_b_d = 1'b0;
                busy_d      = 1'b1;
            end
            ST_RUN: begin
                data_d = rd_entry_s.data;
                func_d = rd_entry_s.func;
                busy_d = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            index_q     <= '0;
            data_q      <= 4'd0;
            func_q      <= IDLE_FUNCTION;
            alu_rst_b_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            index_q     <= index_d;
            data_q      <= data_d;
            func_q      <= func_d;
            alu_rst_b_q <= alu_rst_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.Data       = data_q;
    assign bus.Function   = func_q;
    assign bus.AluReset_b = alu_rst_b_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.Full       = full_s;
    assign bus.Count      = count_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream stage of the registered 4-bit ALU.
- Holds a small program of (Function, Data) operations, loaded one entry per cycle while idle.
- On Start, it clears the ALU accumulator for one cycle, then presents one operation per clock on the ALU's Data/Function inputs.
- Signals Done when the ALU has captured the last operation, which lets a board-level test run a whole accumulate sequence without toggling switches per step.

Parameters:
DEPTH, 8, number of program entries; power of two, minimum 2.
IDLE_FUNCTION, 3'b111, Function code driven whenever no program entry is being issued.

Ports:
Clock  input  1  system clock, rising edge.
Reset_b  input  1  asynchronous, active-low reset.
Clear  input  1  empties the program (IDLE) or aborts a run (CLEAR/RUN).
Load  input  1  write LoadFunction/LoadData as the next program entry.
LoadFunction  input  3  Function code of the entry being loaded.
LoadData  input  4  Data operand of the entry being loaded.
Start  input  1  begin issuing the stored program.
Data  output  4  operand to the ALU Data input, registered.
Function  output  3  op code to the ALU Function input, registered.
AluReset_b  output  1  active-low synchronous clear for the ALU, registered.
Busy  output  1  high in CLEAR and RUN.
Done  output  1  one-cycle pulse once the last entry has been captured by the ALU.
Full  output  1  Count == DEPTH.
Count  output  $clog2(DEPTH)+1  number of stored entries.

Behaviour:
- Reset: the single clock is Clock. Reset_b is asynchronous and active-low. While Reset_b is low:
  - state = IDLE, Count = 0, index = 0;
  - Data = 0, Function = IDLE_FUNCTION;
  - AluReset_b = 1, Busy = 0, Done = 0;
  - memory contents are don't-care.
- Storage:
  - DEPTH x 7-bit memory of {Function, Data}.
  - Entries persist after a run, so Start reruns the same program.
- IDLE:
  - Outputs Data = 0, Function = IDLE_FUNCTION, AluReset_b = 1.
  - Priority is Clear > Start > Load.
  - Clear sets Count = 0.
  - Start with Count > 0 moves to CLEAR next cycle. Start with Count == 0 is ignored and stays in IDLE, with no Done.
  - Load with Count < DEPTH writes mem[Count] and increments Count. Load while Full is ignored and Count holds.
- CLEAR (exactly 1 cycle):
  - AluReset_b = 0, Data = 0, Function = IDLE_FUNCTION.
  - index = 0.
  - Next state is RUN.
- RUN:
  - In cycle k (k = 0..Count-1): Data/Function = mem[k], AluReset_b = 1.
  - After the cycle with k = Count-1, go to DONE.
- DONE (1 cycle):
  - Done = 1, Busy = 0, outputs return to idle values. The ALU has captured the last entry at the edge entering DONE.
  - Next state is IDLE.
- Latency:
  - Start sampled at edge E puts AluReset_b low during cycle E+1 and mem[0] during cycle E+2.
  - Done is high during cycle E+2+Count.
  - The ALU result of the full program is valid from that same cycle.
- Ignored inputs:
  - Start and Load are ignored in CLEAR, RUN and DONE. Count does not change.
  - Clear in DONE is ignored.
- Abort: Clear in CLEAR or RUN returns to IDLE next cycle.
  - Outputs go to idle values, AluReset_b = 1, no Done.
  - Count is preserved, so an abort is not an erase.
- Simultaneous events:
  - Clear + Load in IDLE: Clear wins and Count = 0.
  - Start + Load in IDLE: Start wins and the load is dropped.
- Reset mid-run: all state and outputs return to reset values immediately (asynchronous).

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, CLEAR, RUN, DONE);
  - the ALU Function code constants (ADD_FA = 3'b000, ADD = 3'b001, SEXT = 3'b010, OR_RED = 3'b011, AND_RED = 3'b100, SHL = 3'b101, MUL = 3'b110, HOLD = 3'b111);
  - the entry width (7).
- One natural sub-module, op_program_ram:
  - DEPTH x 7 storage;
  - synchronous write, combinational read by index.
- FSM, counters and output registers stay in alu_op_sequencer.

Test Plan:
- Reset mid-RUN with Count=3 at k=1 -> Count=0, Busy=0, Function=3'b111, Data=0, AluReset_b=1 immediately, without waiting for a clock edge.
- Load (001,3), (001,4), (001,2), then Start -> one cycle AluReset_b=0; then Function/Data = 001/3, 001/4, 001/2 on consecutive cycles; Done next cycle. With the ALU attached, ALUout reads 3, 7, 9.
- Load 9 entries with DEPTH=8 -> Full=1 after the 8th, Count stays 8. Run issues exactly 8 entries, and Done arrives 10 cycles after the Start edge.
- Start with Count=0 -> no CLEAR cycle, Busy stays 0, Done never pulses. Clear + Load in the same IDLE cycle -> Count=0.
- Clear at RUN k=1 of a 3-entry program -> IDLE next cycle, no Done, Count=3. A second Start reissues all 3 entries from k=0.
- Load and Start asserted during RUN -> ignored: Count unchanged, the program issues unaltered, exactly one Done.
